// File: rtl/memory_access_stage.sv
// MEM pipeline stage: runs load/store accesses over a req/ack data-memory
// handshake, steers byte lanes, extends load data and emits one write-back packet per instruction.
module memory_access_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] alu_y,
  input  logic [XLEN-1:0] rdd2,
  input  logic [RAW-1:0]  rd,
  input  logic [2:0]      funct3,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  output logic            dm_req,
  output logic            dm_we,
  output logic [XLEN-1:0] dm_addr,
  output logic [XLEN-1:0] dm_wdata,
  output logic [3:0]      dm_be,
  input  logic            dm_ack,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            wb_valid,
  output logic            wb_regwe,
  output logic [RAW-1:0]  wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_fault
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] off,
                                        input logic is_store);
    logic f;
    f = 1'b0;
    case (f3)
      3'd0:    f = 1'b0;
      3'd1:    f = off[0];
      3'd2:    f = (off != 2'b00);
      3'd4:    f = is_store;
      3'd5:    f = is_store | off[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      3'd0:    be = 4'b0001 << off;
      3'd1:    be = off[1] ? 4'b1100 : 4'b0011;
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    w = d;
    case (f3)
      3'd0:    w = {(XLEN/8){d[7:0]}};
      3'd1:    w = {(XLEN/16){d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    r = w;
    case (f3)
      3'd0:    r = {{(XLEN-8){b[7]}}, b};
      3'd1:    r = {{(XLEN-16){h[15]}}, h};
      3'd4:    r = {{(XLEN-8){1'b0}}, b};
      3'd5:    r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  state_t          state_r, state_s;
  logic            ex_ready_r, ex_ready_s;
  logic            dm_req_r, dm_req_s, dm_we_r, dm_we_s;
  logic [XLEN-1:0] dm_addr_r, dm_addr_s, dm_wdata_r, dm_wdata_s;
  logic [3:0]      dm_be_r, dm_be_s;
  logic            wb_valid_r, wb_valid_s, wb_regwe_r, wb_regwe_s;
  logic [RAW-1:0]  wb_rd_r, wb_rd_s;
  logic [XLEN-1:0] wb_data_r, wb_data_s;
  logic            mem_fault_r, mem_fault_s;
  logic [2:0]      pend_f3_r, pend_f3_s;
  logic [1:0]      pend_off_r, pend_off_s;
  logic            pend_load_r, pend_load_s, pend_regwe_r, pend_regwe_s;

  logic            is_mem_s, is_store_s, fault_s;
  logic [1:0]      off_s;

  // A set mem_read wins over mem_write, so a both-set op is treated as a load.
  assign is_mem_s   = mem_read | mem_write;
  assign is_store_s = mem_write & ~mem_read;
  assign off_s      = alu_y[1:0];
  assign fault_s    = access_fault(funct3, off_s, is_store_s);

  // Next-state and next-output decode for the IDLE/WAIT access FSM
  always_comb begin
    state_s      = state_r;
    dm_req_s     = dm_req_r;
    dm_we_s      = dm_we_r;
    dm_addr_s    = dm_addr_r;
    dm_wdata_s   = dm_wdata_r;
    dm_be_s      = dm_be_r;
    wb_valid_s   = 1'b0;
    mem_fault_s  = 1'b0;
    wb_regwe_s   = wb_regwe_r;
    wb_rd_s      = wb_rd_r;
    wb_data_s    = wb_data_r;
    pend_f3_s    = pend_f3_r;
    pend_off_s   = pend_off_r;
    pend_load_s  = pend_load_r;
    pend_regwe_s = pend_regwe_r;
    case (state_r)
      ST_IDLE: begin
        if (ex_valid) begin
          wb_rd_s = rd;
          if (!is_mem_s) begin
            wb_valid_s = 1'b1;
            wb_regwe_s = reg_write;
            wb_data_s  = alu_y;
          end else if (fault_s) begin
            wb_valid_s  = 1'b1;
            mem_fault_s = 1'b1;
            wb_regwe_s  = 1'b0;
            wb_data_s   = alu_y;
          end else begin
            dm_req_s     = 1'b1;
            dm_we_s      = is_store_s;
            dm_addr_s    = {alu_y[XLEN-1:2], 2'b00};
            dm_be_s      = is_store_s ? store_be(funct3, off_s) : 4'b1111;
            dm_wdata_s   = is_store_s ? store_data(funct3, rdd2) : {XLEN{1'b0}};
            pend_f3_s    = funct3;
            pend_off_s   = off_s;
            pend_load_s  = ~is_store_s;
            pend_regwe_s = reg_write;
            state_s      = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dm_ack) begin
          dm_req_s   = 1'b0;
          state_s    = ST_IDLE;
          wb_valid_s = 1'b1;
          wb_regwe_s = pend_load_r & pend_regwe_r;
          wb_data_s  = pend_load_r ? load_extend(pend_f3_r, pend_off_r, dm_rdata) : {XLEN{1'b0}};
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        dm_req_s = 1'b0;
      end
    endcase
    ex_ready_s = (state_s == ST_IDLE);
  end

  // State, pending-access and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ex_ready_r   <= 1'b1;
      dm_req_r     <= 1'b0;
      dm_we_r      <= 1'b0;
      dm_addr_r    <= {XLEN{1'b0}};
      dm_wdata_r   <= {XLEN{1'b0}};
      dm_be_r      <= 4'b0000;
      wb_valid_r   <= 1'b0;
      wb_regwe_r   <= 1'b0;
      wb_rd_r      <= {RAW{1'b0}};
      wb_data_r    <= {XLEN{1'b0}};
      mem_fault_r  <= 1'b0;
      pend_f3_r    <= 3'd0;
      pend_off_r   <= 2'd0;
      pend_load_r  <= 1'b0;
      pend_regwe_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      ex_ready_r   <= ex_ready_s;
      dm_req_r     <= dm_req_s;
      dm_we_r      <= dm_we_s;
      dm_addr_r    <= dm_addr_s;
      dm_wdata_r   <= dm_wdata_s;
      dm_be_r      <= dm_be_s;
      wb_valid_r   <= wb_valid_s;
      wb_regwe_r   <= wb_regwe_s;
      wb_rd_r      <= wb_rd_s;
      wb_data_r    <= wb_data_s;
      mem_fault_r  <= mem_fault_s;
      pend_f3_r    <= pend_f3_s;
      pend_off_r   <= pend_off_s;
      pend_load_r  <= pend_load_s;
      pend_regwe_r <= pend_regwe_s;
    end
  end

  assign ex_ready  = ex_ready_r;
  assign dm_req    = dm_req_r;
  assign dm_we     = dm_we_r;
  assign dm_addr   = dm_addr_r;
  assign dm_wdata  = dm_wdata_r;
  assign dm_be     = dm_be_r;
  assign wb_valid  = wb_valid_r;
  assign wb_regwe  = wb_regwe_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;
  assign mem_fault = mem_fault_r;

endmodule
